// File: rtl/ibuffer_if.sv
// ibuffer_if: groups the fetch-line input bus and the decode-side
// valid/ready instruction bus of the instruction buffer.
//   slave  modport: used by the instruction buffer (receives lines, presents instructions)
//   master modport: used by the environment (drives lines, consumes instructions)
// Signals:
//   line_valid, line_data[511:0], line_pc[47:0], cancel_pc_fetch : fetch line
//   inst_valid, inst[31:0], inst_pc[47:0], inst_ready           : decode handshake
interface ibuffer_if;
    logic         line_valid;
    logic [511:0] line_data;
    logic [47:0]  line_pc;
    logic         cancel_pc_fetch;
    logic         inst_valid;
    logic [31:0]  inst;
    logic [47:0]  inst_pc;
    logic         inst_ready;

    modport slave (
        input  line_valid, line_data, line_pc, cancel_pc_fetch, inst_ready,
        output inst_valid, inst, inst_pc
    );

    modport master (
        output line_valid, line_data, line_pc, cancel_pc_fetch, inst_ready,
        input  inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/ibuffer.sv
// ibuffer: instruction buffer between the fetch path and decode.
// Splits 64-byte fetch lines into 32-bit instructions tagged with their PC,
// queues them in a circular FIFO of DEPTH entries and presents one per cycle
// to decode. Generates the fetch_inst request pulse and drops stale lines on
// flush (clear_ibuffer | redirect_valid) or cancel_pc_fetch.
// Ports:
//   clock, reset (synchronous, active-high)
//   can_fetch_inst in / fetch_inst out : request handshake with the PC controller
//   clear_ibuffer, redirect_valid in   : flush sources
//   ibuf_overflow out                  : sticky, cleared only by reset
//   ib (ibuffer_if.slave)              : fetch line in, instruction out
// Optional feature macro: IBUF_PERF_CNT_EN adds perf_starve_cnt/perf_drop_cnt.
module ibuffer #(
    parameter int DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        can_fetch_inst,
    output logic        fetch_inst,
    input  logic        clear_ibuffer,
    input  logic        redirect_valid,
    output logic        ibuf_overflow,
`ifdef IBUF_PERF_CNT_EN
    output logic [31:0] perf_starve_cnt,
    output logic [31:0] perf_drop_cnt,
`endif
    ibuffer_if.slave    ib
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_inst_r [DEPTH];
    logic [47:0]   mem_pc_r   [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          pending_r;
    logic          fetch_inst_r;
    logic          inst_valid_r;
    logic [31:0]   inst_r;
    logic [47:0]   inst_pc_r;
    logic          overflow_r;

    logic          flush_s;
    logic [3:0]    offset_s;
    logic [CW-1:0] n_s;
    logic [CW-1:0] free_s;
    logic          line_acc_s;
    logic          wr_en_s;
    logic          ovf_set_s;
    logic          rd_en_s;
    logic          req_s;
    logic [AW-1:0] head_nxt_s;
    logic [AW-1:0] tail_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic          pending_nxt_s;
    logic [AW-1:0] rel_s;
    logic          rel_hit_s;
    logic [3:0]    wsel_s;
    logic [31:0]   head_inst_nxt_s;
    logic [47:0]   head_pc_nxt_s;
    logic          unused_pc_bits_s;

    // Byte offset bits of the line PC carry no information.
    assign unused_pc_bits_s = ^ib.line_pc[1:0];

    // Next-state computation for pointers, count, request and head lookahead.
    always_comb begin
        flush_s    = clear_ibuffer | redirect_valid;
        offset_s   = ib.line_pc[5:2];
        n_s        = CW'(5'd16) - CW'(offset_s);
        free_s     = CW'(DEPTH) - count_r;
        line_acc_s = ib.line_valid & ~ib.cancel_pc_fetch & ~flush_s;
        wr_en_s    = line_acc_s & (n_s <= free_s);
        ovf_set_s  = line_acc_s & (n_s > free_s);
        rd_en_s    = (count_r != {CW{1'b0}}) & ib.inst_ready & ~flush_s;
        req_s      = can_fetch_inst & ~pending_r & (free_s >= CW'(5'd16))
                     & ~flush_s & ~fetch_inst_r;

        head_nxt_s  = flush_s ? {AW{1'b0}} : (rd_en_s ? head_r + AW'(1'b1) : head_r);
        tail_nxt_s  = flush_s ? {AW{1'b0}} : (wr_en_s ? tail_r + AW'(n_s) : tail_r);
        count_nxt_s = flush_s ? {CW{1'b0}} :
                      count_r + (wr_en_s ? n_s : {CW{1'b0}}) - (rd_en_s ? CW'(1'b1) : {CW{1'b0}});

        // An accepted line clears pending, but a request issued in the same
        // cycle is still outstanding and keeps it set.
        pending_nxt_s = flush_s ? 1'b1 : (req_s ? 1'b1 : (line_acc_s ? 1'b0 : pending_r));

        // The registered head output must reflect a slot that is being written
        // this very cycle (e.g. a write into an empty buffer), so look through
        // the write port when the next head falls inside the written window.
        rel_s           = head_nxt_s - tail_r;
        rel_hit_s       = wr_en_s & ({1'b0, rel_s} < n_s);
        wsel_s          = offset_s + rel_s[3:0];
        head_inst_nxt_s = rel_hit_s ? ib.line_data[{wsel_s, 5'b00000} +: 32]
                                    : mem_inst_r[head_nxt_s];
        head_pc_nxt_s   = rel_hit_s ? {ib.line_pc[47:6], wsel_s, 2'b00}
                                    : mem_pc_r[head_nxt_s];
    end

    // State registers, storage writes and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_r[i] <= 32'd0;
                mem_pc_r[i]   <= 48'd0;
            end
            head_r       <= {AW{1'b0}};
            tail_r       <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            pending_r    <= 1'b0;
            fetch_inst_r <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 48'd0;
            overflow_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                for (int k = 0; k < 16; k++) begin
                    if (4'(k) >= offset_s) begin
                        mem_inst_r[tail_r + AW'(4'(k) - offset_s)] <= ib.line_data[32*k +: 32];
                        mem_pc_r[tail_r + AW'(4'(k) - offset_s)]   <= {ib.line_pc[47:6], 4'(k), 2'b00};
                    end
                end
            end
            head_r       <= head_nxt_s;
            tail_r       <= tail_nxt_s;
            count_r      <= count_nxt_s;
            pending_r    <= pending_nxt_s;
            fetch_inst_r <= req_s;
            inst_valid_r <= (count_nxt_s != {CW{1'b0}});
            inst_r       <= head_inst_nxt_s;
            inst_pc_r    <= head_pc_nxt_s;
            overflow_r   <= overflow_r | ovf_set_s;
        end
    end

`ifdef IBUF_PERF_CNT_EN
    logic [31:0] perf_starve_r;
    logic [31:0] perf_drop_r;

    // Starvation and dropped-line counters; both wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_starve_r <= 32'd0;
            perf_drop_r   <= 32'd0;
        end else begin
            if (ib.inst_ready && (count_r == {CW{1'b0}})) begin
                perf_starve_r <= perf_starve_r + 32'd1;
            end
            if (ib.line_valid && (ib.cancel_pc_fetch || flush_s)) begin
                perf_drop_r <= perf_drop_r + 32'd1;
            end
        end
    end

    assign perf_starve_cnt = perf_starve_r;
    assign perf_drop_cnt   = perf_drop_r;
`endif

    assign fetch_inst    = fetch_inst_r;
    assign ibuf_overflow = overflow_r;
    assign ib.inst_valid = inst_valid_r;
    assign ib.inst       = inst_r;
    assign ib.inst_pc    = inst_pc_r;
endmodule
